// File: rtl/flags_unit_pkg.sv
// Shared CPU status-flag definitions: bit positions, ALU operation classes,
// and the arithmetic-flag rule used by the flags producer.
package flags_unit_pkg;

    localparam int FLAG_N = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_C = 3;
    localparam int FLAG_I = 4;

    localparam logic [7:0] FLAGS_RESERVED_MASK = 8'hE0;
    localparam logic [7:0] FLAGS_ARITH_MASK    = 8'h0F;

    typedef enum logic [1:0] {
        ALU_KIND_ADD   = 2'd0,
        ALU_KIND_SUB   = 2'd1,
        ALU_KIND_LOGIC = 2'd2,
        ALU_KIND_SHIFT = 2'd3
    } alu_kind_e;

    // Returns {C, V, Z, N} for one ALU operation.
    function automatic logic [3:0] alu_flags(
        input alu_kind_e  kind,
        input logic [7:0] a,
        input logic [7:0] b,
        input logic [7:0] r,
        input logic       carry
    );
        logic c;
        logic v;
        c = 1'b0;
        v = 1'b0;
        case (kind)
            ALU_KIND_ADD: begin
                c = carry;
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            ALU_KIND_SUB: begin
                c = carry;
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            ALU_KIND_SHIFT: c = carry;
            default: ;
        endcase
        return {c, v, (r == 8'h00), r[7]};
    endfunction

endpackage

// File: rtl/flags_if.sv
// Execute-stage bundle between the ALU/control side and the flags unit.
interface flags_if;
    logic       alu_valid;
    logic [1:0] alu_kind;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [7:0] alu_result;
    logic       alu_carry;
    logic       flag_we;
    logic [7:0] flag_wdata;
    logic       save;
    logic       restore;
    logic [7:0] flags;
    logic       stack_empty;
    logic       stack_full;
    logic       stack_err;

    modport master (
        output alu_valid, alu_kind, op_a, op_b, alu_result, alu_carry,
        output flag_wdata, flag_we, save, restore,
        input  flags, stack_empty, stack_full, stack_err
    );

    modport slave (
        input  alu_valid, alu_kind, op_a, op_b, alu_result, alu_carry,
        input  flag_wdata, flag_we, save, restore,
        output flags, stack_empty, stack_full, stack_err
    );
endinterface

// File: rtl/flags_shadow_stack.sv
// LIFO of saved flag words for nested interrupts; reports full/empty and a
// sticky error for overflow, underflow or a simultaneous push and pop.
module flags_shadow_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] pop_data,
    output logic         push_ok,
    output logic         pop_ok,
    output logic         empty,
    output logic         full,
    output logic         err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] SP_ONE   = (AW + 1)'(1);
    localparam logic [AW:0] SP_DEPTH = (AW + 1)'(DEPTH);

    logic [AW:0]   sp_reg;
    logic          err_reg;
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] top_idx;
    logic          bad_req;

    assign empty   = (sp_reg == '0);
    assign full    = (sp_reg == SP_DEPTH);
    assign err     = err_reg;
    assign push_ok = push && !pop && !full;
    assign pop_ok  = pop && !push && !empty;
    // Conflicting or impossible requests are dropped and only flag the error.
    assign bad_req = (push && pop) || (push && full) || (pop && empty);

    assign top_idx  = AW'(sp_reg - SP_ONE);
    assign pop_data = mem[top_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_reg  <= '0;
            err_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[sp_reg[AW-1:0]] <= push_data;
                sp_reg              <= sp_reg + SP_ONE;
            end else if (pop_ok) begin
                sp_reg <= sp_reg - SP_ONE;
            end
            if (bad_req) begin
                err_reg <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/flags_unit.sv
// Architectural status-flags register: ALU flag generation, explicit load,
// and interrupt save/restore through the shadow stack.
module flags_unit
    import flags_unit_pkg::*;
#(
    parameter int STACK_DEPTH = 4,
    parameter int FLAG_W      = 8
) (
    input  logic    clk,
    input  logic    reset,
    flags_if.slave  bus
);
    logic [FLAG_W-1:0] flags_reg;
    logic [FLAG_W-1:0] flags_next;
    logic [FLAG_W-1:0] pop_data;
    logic              push_ok;
    logic              pop_ok;
    logic [3:0]        arith;

    flags_shadow_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (FLAG_W)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (bus.save),
        .pop       (bus.restore),
        .push_data (flags_reg),
        .pop_data  (pop_data),
        .push_ok   (push_ok),
        .pop_ok    (pop_ok),
        .empty     (bus.stack_empty),
        .full      (bus.stack_full),
        .err       (bus.stack_err)
    );

    assign arith = alu_flags(alu_kind_e'(bus.alu_kind), bus.op_a, bus.op_b,
                             bus.alu_result, bus.alu_carry);

    // Stack requests shadow load and ALU updates even when they are rejected.
    always_comb begin
        flags_next = flags_reg;
        if (bus.save || bus.restore) begin
            if (push_ok) begin
                flags_next[FLAG_I] = 1'b0;
            end else if (pop_ok) begin
                flags_next = pop_data;
            end
        end else if (bus.flag_we) begin
            flags_next = bus.flag_wdata & ~FLAGS_RESERVED_MASK;
        end else if (bus.alu_valid) begin
            flags_next[3:0] = arith;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_reg <= '0;
        end else begin
            flags_reg <= flags_next;
        end
    end

    assign bus.flags = flags_reg;

endmodule

// File: tb/tb_flags_unit.sv
// Self-checking bench for flags_unit: directed scenarios with literal
// expectations, then randomized traffic against a queue-based model.
module tb_flags_unit;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    flags_if bus ();

    flags_unit #(.STACK_DEPTH(DEPTH), .FLAG_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Behavioural model: flags byte, a queue as the shadow stack, sticky error.
    logic [7:0] m_flags = 8'h00;
    logic [7:0] m_stack[$];
    bit         m_err = 1'b0;

    function automatic logic [7:0] model_alu(input logic [7:0] f, input logic [1:0] kind,
                                             input logic [7:0] a, input logic [7:0] b,
                                             input logic [7:0] r, input logic cin);
        int  sa, sb, s;
        bit  c, v;
        logic [7:0] o;
        sa = $signed(a);
        sb = $signed(b);
        c  = 1'b0;
        v  = 1'b0;
        case (kind)
            2'd0: begin s = sa + sb; v = (s > 127) || (s < -128); c = cin; end
            2'd1: begin s = sa - sb; v = (s > 127) || (s < -128); c = cin; end
            2'd3: c = cin;
            default: ;
        endcase
        o = f;
        o[3] = c;
        o[2] = v;
        o[1] = (r == 8'h00);
        o[0] = r[7];
        return o;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_flags = 8'h00;
            m_stack.delete();
            m_err = 1'b0;
        end else if (bus.save && bus.restore) begin
            m_err = 1'b1;
        end else if (bus.save) begin
            if (m_stack.size() == DEPTH) m_err = 1'b1;
            else begin
                m_stack.push_back(m_flags);
                m_flags[4] = 1'b0;
            end
        end else if (bus.restore) begin
            if (m_stack.size() == 0) m_err = 1'b1;
            else m_flags = m_stack.pop_back();
        end else if (bus.flag_we) begin
            m_flags = {3'b000, bus.flag_wdata[4:0]};
        end else if (bus.alu_valid) begin
            m_flags = model_alu(m_flags, bus.alu_kind, bus.op_a, bus.op_b,
                                bus.alu_result, bus.alu_carry);
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            n_checks += 4;
            if (bus.flags !== m_flags) begin
                n_fail++;
                $display("FAIL model_flags t=%0t got=%h exp=%h", $time, bus.flags, m_flags);
            end
            if (bus.stack_empty !== (m_stack.size() == 0)) begin
                n_fail++;
                $display("FAIL model_empty t=%0t got=%b exp=%b", $time, bus.stack_empty, m_stack.size() == 0);
            end
            if (bus.stack_full !== (m_stack.size() == DEPTH)) begin
                n_fail++;
                $display("FAIL model_full t=%0t got=%b exp=%b", $time, bus.stack_full, m_stack.size() == DEPTH);
            end
            if (bus.stack_err !== m_err) begin
                n_fail++;
                $display("FAIL model_err t=%0t got=%b exp=%b", $time, bus.stack_err, m_err);
            end
        end
    end

    task automatic lit(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end else begin
            $display("check %s = %h", name, got);
        end
    endtask

    task automatic idle();
        bus.alu_valid = 0; bus.alu_kind = 0; bus.op_a = 0; bus.op_b = 0;
        bus.alu_result = 0; bus.alu_carry = 0; bus.flag_we = 0; bus.flag_wdata = 0;
        bus.save = 0; bus.restore = 0; reset = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
        idle();
    endtask

    task automatic alu(input logic [1:0] k, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] r, input logic c);
        bus.alu_valid = 1; bus.alu_kind = k; bus.op_a = a; bus.op_b = b;
        bus.alu_result = r; bus.alu_carry = c;
        cyc();
    endtask

    task automatic load(input logic [7:0] d);
        bus.flag_we = 1; bus.flag_wdata = d;
        cyc();
    endtask

    task automatic do_save();
        bus.save = 1;
        cyc();
    endtask

    task automatic do_restore();
        bus.restore = 1;
        cyc();
    endtask

    task automatic rand_alu();
        logic [7:0] a, b, r;
        logic [8:0] s;
        logic       c;
        logic [1:0] k;
        logic [7:0] edges [4];
        edges = '{8'h00, 8'h7F, 8'h80, 8'hFF};
        k = 2'($urandom_range(0, 3));
        a = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : 8'($urandom);
        b = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : 8'($urandom);
        c = 1'($urandom);
        case (k)
            2'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; end
            2'd1: begin r = a - b; c = (a < b); end
            2'd2: case ($urandom_range(0, 2))
                      0: r = a & b;
                      1: r = a | b;
                      default: r = a ^ b;
                  endcase
            default: if ($urandom_range(0, 1) == 1) begin r = a << 1; c = a[7]; end
                     else begin r = a >> 1; c = a[0]; end
        endcase
        bus.alu_kind = k; bus.op_a = a; bus.op_b = b; bus.alu_result = r; bus.alu_carry = c;
    endtask

    initial begin
        idle();
        reset = 1;
        cyc();
        chk_en = 1'b1;
        lit("reset_flags", bus.flags, 8'h00);
        lit("reset_empty", {7'b0, bus.stack_empty}, 8'h01);
        lit("reset_err",   {7'b0, bus.stack_err},   8'h00);

        alu(2'd0, 8'h7F, 8'h01, 8'h80, 1'b0);
        lit("add_overflow", bus.flags, 8'h05);
        alu(2'd1, 8'h10, 8'h20, 8'hF0, 1'b1);
        lit("sub_borrow", bus.flags, 8'h09);
        alu(2'd2, 8'h0F, 8'hF0, 8'h00, 1'b1);
        lit("logic_zero", bus.flags, 8'h02);

        load(8'hFF);
        lit("load_mask", bus.flags, 8'h1F);
        do_save();
        lit("save_clr_i", bus.flags, 8'h0F);
        lit("save_nonempty", {7'b0, bus.stack_empty}, 8'h00);
        do_restore();
        lit("restore_val", bus.flags, 8'h1F);
        lit("restore_empty", {7'b0, bus.stack_empty}, 8'h01);

        for (int i = 0; i < 5; i++) begin
            load(8'(8'h10 + i));
            do_save();
            if (i == 3) lit("full_after_4", {7'b0, bus.stack_full}, 8'h01);
            if (i == 3) lit("no_err_at_4", {7'b0, bus.stack_err}, 8'h00);
        end
        lit("err_after_5", {7'b0, bus.stack_err}, 8'h01);
        lit("flags_on_overflow", bus.flags, 8'h14);
        for (int i = 3; i >= 0; i--) begin
            do_restore();
            lit($sformatf("lifo_%0d", i), bus.flags, 8'(8'h10 + i));
        end
        do_restore();
        lit("underflow_hold", bus.flags, 8'h10);

        reset = 1;
        cyc();
        bus.flag_we = 1; bus.flag_wdata = 8'h01;
        bus.alu_valid = 1; bus.alu_kind = 2'd2; bus.alu_result = 8'h00;
        cyc();
        lit("we_beats_alu", bus.flags, 8'h01);

        do_save();
        bus.save = 1; bus.restore = 1;
        cyc();
        lit("conflict_err", {7'b0, bus.stack_err}, 8'h01);
        lit("conflict_sp", {6'b0, bus.stack_full, bus.stack_empty}, 8'h00);
        lit("conflict_flags", bus.flags, 8'h01);
        reset = 1;
        cyc();
        lit("midreset_flags", bus.flags, 8'h00);
        lit("midreset_empty", {7'b0, bus.stack_empty}, 8'h01);
        lit("midreset_err", {7'b0, bus.stack_err}, 8'h00);

        for (int n = 0; n < 3000; n++) begin
            int p;
            p = $urandom_range(0, 99);
            rand_alu();
            bus.alu_valid  = ($urandom_range(0, 9) < 7);
            bus.flag_we    = ($urandom_range(0, 9) == 0);
            bus.flag_wdata = 8'($urandom);
            bus.save       = (p < 16) || (p >= 94);
            bus.restore    = (p >= 16 && p < 32) || (p >= 94);
            reset          = ($urandom_range(0, 199) == 0);
            @(posedge clk);
            #2;
        end
        idle();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/flags_unit.md
Name: flags_unit

Overview:
- Producer side of the CPU status flags consumed by the branch-condition checker.
- Computes carry, overflow, zero and negative from each ALU operation and holds them in the architectural 8-bit flags register.
- Supports an explicit flags load, and an interrupt save/restore through a small shadow stack.
- Sits beside the ALU in the execute stage. Its registered `flags` output feeds branch evaluation directly.

Parameters:
- STACK_DEPTH, 4: number of shadow-stack entries for nested interrupt save/restore (power of two, ≥2).
- FLAG_W, 8: width of the flags register.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU result this cycle; update the arithmetic flags.
- alu_kind  in  2  operation class: 0 ADD, 1 SUB, 2 LOGIC, 3 SHIFT.
- op_a  in  8  ALU operand A.
- op_b  in  8  ALU operand B.
- alu_result  in  8  ALU result.
- alu_carry  in  1  ADD carry-out, SUB borrow, or SHIFT shifted-out bit.
- flag_we  in  1  load the flags register from flag_wdata.
- flag_wdata  in  8  flags load value.
- save  in  1  interrupt entry: push flags onto the shadow stack.
- restore  in  1  interrupt return: pop flags from the shadow stack.
- flags  out  8  registered flags. Bit layout: [3]=C, [2]=V, [1]=Z, [0]=N, [4]=I (interrupt enable), [7:5] reserved, always 0.
- stack_empty  out  1  shadow stack holds no entries.
- stack_full  out  1  shadow stack holds STACK_DEPTH entries.
- stack_err  out  1  sticky overflow/underflow/conflict error.

Behaviour:
- Reset (synchronous, takes precedence over everything):
  - flags = 8'h00, stack pointer = 0.
  - stack_empty = 1, stack_full = 0, stack_err = 0.
- Latency: every update is visible on `flags` one cycle after the request edge. No combinational input→output path.
- Per-cycle priority, highest first: reset > save/restore > flag_we > alu_valid. Only the highest-priority request takes effect; lower ones in the same cycle are dropped.
- ALU flag rules (only bits 3:0 change; I is untouched):
  - Z = (alu_result == 0). N = alu_result[7].
  - ADD: C = alu_carry; V = (op_a[7] == op_b[7]) && (alu_result[7] != op_a[7]).
  - SUB (A−B): C = alu_carry, meaning borrow, so C=1 iff A<B unsigned; V = (op_a[7] != op_b[7]) && (alu_result[7] != op_a[7]).
  - LOGIC: C = 0, V = 0.
  - SHIFT: C = alu_carry, V = 0.
- flag_we: flags = {3'b000, flag_wdata[4:0]}. Reserved bits are forced to 0.
- save, not full:
  - Write flags to stack[sp]; sp++.
  - Next flags = current flags with I cleared; arithmetic bits are kept.
- save, full: stack and flags unchanged; stack_err set.
- restore, not empty: sp--; flags = stack[sp−1] (the restored value includes I).
- restore, empty: flags unchanged; stack_err set.
- save and restore in the same cycle: both ignored, stack_err set.
- stack_err clears only on reset.
- stack_empty = (sp == 0). stack_full = (sp == STACK_DEPTH). Both are derived from the registered sp, with no wrap-around.
- Reset asserted mid-sequence discards all stacked entries.

Decomposition:
- Shared package / include (extends the existing CPU data include):
  - Flag bit indices: FLAG_C=3, FLAG_V=2, FLAG_Z=1, FLAG_N=0, FLAG_I=4.
  - ALU_KIND_ADD/SUB/LOGIC/SHIFT encodings.
  - FLAGS_RESERVED_MASK = 8'hE0.
- One sub-module, `flags_shadow_stack`: the LIFO with push/pop, sp counter, full/empty and error detection. flags_unit keeps the flag computation and priority muxing.

Test Plan:
- Reset then ADD with op_a=8'h7F, op_b=8'h01, result=8'h80, carry=0 → next cycle flags=8'h05 (V=1, N=1).
- SUB with op_a=8'h10, op_b=8'h20, result=8'hF0, carry=1 → flags=8'h09 (C=1, N=1). Then LOGIC with result=8'h00 → flags=8'h02.
- flag_we with flag_wdata=8'hFF → flags=8'h1F. Then save → flags=8'h0F, stack_empty=0. Then restore → flags=8'h1F, stack_empty=1.
- Depth-4 test: five saves → stack_full=1 after the fourth save, stack_err=1 after the fifth. Then four restores return the pushed values in LIFO order; a fifth restore leaves flags unchanged.
- Same cycle flag_we=1 (8'h01) and alu_valid=1 (result 0) → flags=8'h01; flag_we wins.
- Simultaneous save+restore → sp unchanged, stack_err=1. Assert reset mid-stack → flags=0, stack_empty=1, stack_err=0.
